// File: rtl/sdram_cmd_pkg.sv
// Shared SDRAM command/state definitions.
// Contents:
//   CMD_*       {cs_n,ras_n,cas_n,we_n} command encodings
//   rd_state_e  one-hot state encoding of the read-burst engine
//   A10_BIT     address bit carrying auto-precharge / precharge-all
//   pre_all_addr() address word for a PRECHARGE of all banks
package sdram_cmd_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_BSTOP = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam int A10_BIT = 10;

    typedef enum logic [7:0] {
        RS_IDLE  = 8'b0000_0001,
        RS_ACT   = 8'b0000_0010,
        RS_TRCD  = 8'b0000_0100,
        RS_RD    = 8'b0000_1000,
        RS_DRAIN = 8'b0001_0000,
        RS_PRE   = 8'b0010_0000,
        RS_TRP   = 8'b0100_0000,
        RS_END   = 8'b1000_0000
    } rd_state_e;

    function automatic logic [11:0] pre_all_addr();
        logic [11:0] a;
        a          = '0;
        a[A10_BIT] = 1'b1;
        return a;
    endfunction

endpackage

// File: rtl/sdram_page_reader_if.sv
// Arbiter handshake plus SDRAM read command bus of the page reader.
// master: the read engine (drives rd_req, rd_end, rd_cmd, rd_addr,
//         bank_addr, rd_data_en; receives rd_trig, rd_en, aref_req).
// slave : the arbiter / FIFO / SDRAM side.
interface sdram_page_reader_if;
    logic        rd_trig;
    logic        rd_en;
    logic        aref_req;
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  bank_addr;
    logic        rd_data_en;

    modport master (
        input  rd_trig, rd_en, aref_req,
        output rd_req, rd_end, rd_cmd, rd_addr, bank_addr, rd_data_en
    );

    modport slave (
        output rd_trig, rd_en, aref_req,
        input  rd_req, rd_end, rd_cmd, rd_addr, bank_addr, rd_data_en
    );
endinterface

// File: rtl/sdram_rd_valid_pipe.sv
// Data-valid strobe generator: delays a command-issue pulse by CL cycles
// and stretches it into a BURST_LEN-cycle window. Back-to-back issues every
// BURST_LEN cycles give a contiguous high.
// Ports: sclk, rst_n (async, active-low), issue (one-cycle pulse in the
//        command issue cycle), data_en (window aligned to valid DQ).
module sdram_rd_valid_pipe #(
    parameter int CL        = 3,
    parameter int BURST_LEN = 4
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic issue,
    output logic data_en
);
    localparam int CW = $clog2(BURST_LEN + 1);

    logic [CL-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = issue;
        for (int i = 1; i < CL; i++) begin
            sr_d[i] = sr_q[i-1];
        end

        // The delayed pulse itself is the first window cycle; the counter
        // covers the remaining BURST_LEN-1.
        cnt_d = cnt_q;
        if (sr_q[CL-1]) begin
            cnt_d = CW'(BURST_LEN - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_en = sr_q[CL-1] | (cnt_q != '0);

endmodule

// File: rtl/sdram_page_reader.sv
// Read-burst engine: on an arbiter grant opens the current row, streams
// gapless READ bursts along it, then precharges all banks and signals
// rd_end. A pending refresh stops the stream at the next burst boundary;
// col/row/bank are kept so the next grant resumes where it stopped.
// Ports: sclk, rst_n (async, active-low), bus (sdram_page_reader_if.master).
//
// state | meaning
// IDLE  | waiting for rd_en; rd_req = pending
// ACT   | ACT command on the bus (row, bank)
// TRCD  | NOP until ACT-to-READ delay met
// RD    | READ issue cycle, then BURST_LEN-1 NOPs per burst
// DRAIN | NOP while last burst's data returns
// PRE   | PRECHARGE all banks
// TRP   | NOP until precharge complete
// END   | rd_end pulse
module sdram_page_reader
    import sdram_cmd_pkg::*;
#(
    parameter int ROW_END   = 937,
    parameter int COL_END   = 256,
    parameter int BURST_LEN = 4,
    parameter int CL        = 3,
    parameter int TRCD      = 2,
    parameter int TRP       = 2
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    sdram_page_reader_if.master  bus
);
    localparam int          TW       = 8;
    localparam logic [11:0] ROW_LAST = 12'(ROW_END - 1);

    rd_state_e   state_q, state_d;
    logic [3:0]  rd_cmd_q, rd_cmd_d;
    logic [11:0] rd_addr_q, rd_addr_d;
    logic [1:0]  bank_addr_q, bank_addr_d;
    logic        rd_end_q, rd_end_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [8:0]  col_q, col_d;
    logic [11:0] row_q, row_d;
    logic [1:0]  bank_q, bank_d;
    logic        pending_q, pending_d;

    logic        issue;
    logic        col_wrap;
    logic        last;
    logic [9:0]  col_nxt;

    always_comb begin
        state_d     = state_q;
        rd_cmd_d    = CMD_NOP;
        rd_addr_d   = rd_addr_q;
        bank_addr_d = bank_addr_q;
        rd_end_d    = 1'b0;
        tmr_d       = tmr_q;
        col_d       = col_q;
        row_d       = row_q;
        bank_d      = bank_q;
        pending_d   = pending_q;

        issue    = (state_q == RS_RD) && (rd_cmd_q == CMD_READ);
        col_nxt  = {1'b0, col_q} + 10'(BURST_LEN);
        col_wrap = (col_nxt == 10'(COL_END));
        last     = col_wrap || bus.aref_req;

        // Column advances at the end of the issue cycle, so col_q is the
        // column on the bus while the stop decision is made.
        if (issue) begin
            col_d = col_wrap ? 9'd0 : col_nxt[8:0];
            if (col_wrap) begin
                pending_d = 1'b0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    bank_d = bank_q + 2'd1;
                end else begin
                    row_d = row_q + 12'd1;
                end
            end
        end
        // A trigger coinciding with the row wrap must not be lost.
        if (bus.rd_trig) begin
            pending_d = 1'b1;
        end

        case (state_q)
            RS_IDLE: begin
                if (bus.rd_en) begin
                    state_d     = RS_ACT;
                    rd_cmd_d    = CMD_ACT;
                    rd_addr_d   = row_q;
                    bank_addr_d = bank_q;
                end
            end
            RS_ACT: begin
                if (TRCD > 1) begin
                    state_d = RS_TRCD;
                    tmr_d   = TW'(TRCD - 2);
                end else begin
                    state_d   = RS_RD;
                    rd_cmd_d  = CMD_READ;
                    rd_addr_d = {3'b000, col_d};
                end
            end
            RS_TRCD: begin
                if (tmr_q == '0) begin
                    state_d   = RS_RD;
                    rd_cmd_d  = CMD_READ;
                    rd_addr_d = {3'b000, col_d};
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RS_RD: begin
                if (issue) begin
                    if (last) begin
                        state_d = RS_DRAIN;
                        tmr_d   = TW'(CL + BURST_LEN - 2);
                    end else if (BURST_LEN > 1) begin
                        tmr_d = TW'(BURST_LEN - 2);
                    end else begin
                        rd_cmd_d  = CMD_READ;
                        rd_addr_d = {3'b000, col_d};
                    end
                end else if (tmr_q == '0) begin
                    rd_cmd_d  = CMD_READ;
                    rd_addr_d = {3'b000, col_d};
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RS_DRAIN: begin
                if (tmr_q == '0) begin
                    state_d   = RS_PRE;
                    rd_cmd_d  = CMD_PRE;
                    rd_addr_d = pre_all_addr();
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RS_PRE: begin
                state_d = RS_TRP;
                tmr_d   = TW'(TRP - 1);
            end
            RS_TRP: begin
                if (tmr_q == '0) begin
                    state_d  = RS_END;
                    rd_end_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RS_END: begin
                state_d = RS_IDLE;
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RS_IDLE;
            rd_cmd_q    <= CMD_NOP;
            rd_addr_q   <= '0;
            bank_addr_q <= '0;
            rd_end_q    <= 1'b0;
            tmr_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bank_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cmd_q    <= rd_cmd_d;
            rd_addr_q   <= rd_addr_d;
            bank_addr_q <= bank_addr_d;
            rd_end_q    <= rd_end_d;
            tmr_q       <= tmr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            pending_q   <= pending_d;
        end
    end

    sdram_rd_valid_pipe #(
        .CL        (CL),
        .BURST_LEN (BURST_LEN)
    ) u_valid_pipe (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .issue   (issue),
        .data_en (bus.rd_data_en)
    );

    assign bus.rd_cmd    = rd_cmd_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.bank_addr = bank_addr_q;
    assign bus.rd_end    = rd_end_q;
    assign bus.rd_req    = pending_q && (state_q == RS_IDLE);

endmodule

// File: tb/tb_sdram_page_reader.sv
module tb_sdram_page_reader;
    import sdram_cmd_pkg::*;

    localparam int ROW_END = 2;
    localparam int COL_END = 256;
    localparam int BL      = 4;
    localparam int CL      = 3;
    localparam int TRCD    = 2;
    localparam int TRP     = 2;
    localparam logic [3:0] EV_END = 4'hF;
    localparam int NO_RST  = 32'h7fff_ffff;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
    } ev_t;

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ev_t  ev_q[$];
    int   de_q[$];
    int   mdl_col, mdl_row, mdl_bank;
    bit   mdl_pending;

    ev_t  mon_ev;
    bit   de_exp;

    sdram_page_reader_if bus();

    sdram_page_reader #(
        .ROW_END   (ROW_END),
        .COL_END   (COL_END),
        .BURST_LEN (BL),
        .CL        (CL),
        .TRCD      (TRCD),
        .TRP       (TRP)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push_ev(input int c, input logic [3:0] cmd,
                                    input logic [11:0] a, input logic [1:0] b);
        ev_t e;
        e.cyc  = 32'(c);
        e.cmd  = cmd;
        e.addr = a;
        e.bank = b;
        ev_q.push_back(e);
    endfunction

    task automatic see_ev(input ev_t got);
        ev_t e;
        n_tests++;
        if (ev_q.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_event: got cyc=%0d cmd=%b addr=%h bank=%0d expected no event",
                     got.cyc, got.cmd, got.addr, got.bank);
        end else begin
            e = ev_q.pop_front();
            if (got != e) begin
                n_fail++;
                $display("FAIL cmd_event: got cyc=%0d cmd=%b addr=%h bank=%0d expected cyc=%0d cmd=%b addr=%h bank=%0d",
                         got.cyc, got.cmd, got.addr, got.bank, e.cyc, e.cmd, e.addr, e.bank);
            end
        end
    endtask

    // Monitor: every non-NOP command, rd_end pulse and rd_data_en cycle is
    // matched against the expectations queued by the stimulus.
    always @(negedge sclk) begin
        if (rst_n) begin
            if (bus.rd_cmd != CMD_NOP) begin
                mon_ev.cyc  = 32'(cyc);
                mon_ev.cmd  = bus.rd_cmd;
                mon_ev.addr = bus.rd_addr;
                mon_ev.bank = bus.bank_addr;
                see_ev(mon_ev);
            end
            if (bus.rd_end) begin
                mon_ev.cyc  = 32'(cyc);
                mon_ev.cmd  = EV_END;
                mon_ev.addr = '0;
                mon_ev.bank = '0;
                see_ev(mon_ev);
            end
            de_exp = (de_q.size() > 0) && (de_q[0] == cyc);
            if (de_exp) void'(de_q.pop_front());
            if (de_exp || bus.rd_data_en) begin
                n_tests++;
                if (bus.rd_data_en !== de_exp) begin
                    n_fail++;
                    $display("FAIL rd_data_en: cyc %0d got %b expected %b", cyc, bus.rd_data_en, de_exp);
                end
            end
        end
    end

    task automatic trig();
        @(negedge sclk);
        bus.rd_trig = 1'b1;
        @(negedge sclk);
        bus.rd_trig = 1'b0;
        mdl_pending = 1'b1;
    endtask

    // aref_k : READ number (1-based) during which aref_req is high, 0 = none
    //          (1 also holds aref_req from the grant cycle on)
    // trig_off: rd_trig offset from grant, -1 = on the last READ, 0 = none
    // en_off : extra rd_en pulse offset from grant, 0 = none
    // rst_off: reset offset from grant, 0 = none
    task automatic grant(input int aref_k, input int trig_off, input int en_off, input int rst_off);
        int t, left, n, r0, last, pre_c, end_c, rst_c, trig_c, stop_c, c;
        bit full;
        @(negedge sclk);
        t      = cyc;
        left   = (COL_END - mdl_col) / BL;
        n      = (aref_k > 0 && aref_k < left) ? aref_k : left;
        full   = (n == left);
        r0     = t + 1 + TRCD;
        last   = r0 + BL * (n - 1);
        pre_c  = last + CL + BL;
        end_c  = pre_c + 1 + TRP;
        rst_c  = (rst_off > 0) ? t + rst_off : NO_RST;
        trig_c = (trig_off < 0) ? last : ((trig_off > 0) ? t + trig_off : -1);
        stop_c = (rst_off > 0) ? rst_c : end_c + 1;

        push_ev(t + 1, CMD_ACT, 12'(mdl_row), 2'(mdl_bank));
        for (int i = 0; i < n; i++) begin
            c = r0 + BL * i;
            if (c <= rst_c) push_ev(c, CMD_READ, 12'(mdl_col + BL * i), 2'(mdl_bank));
            for (int j = 0; j < BL; j++) begin
                if (c + CL + j <= rst_c) de_q.push_back(c + CL + j);
            end
        end
        if (pre_c <= rst_c) push_ev(pre_c, CMD_PRE, 12'h400, 2'(mdl_bank));
        if (end_c <= rst_c) push_ev(end_c, EV_END, 12'h000, 2'd0);

        while (cyc <= stop_c) begin
            bus.rd_en    = (cyc == t) || (en_off > 0 && cyc == t + en_off);
            bus.aref_req = (aref_k > 0 && cyc == r0 + BL * (aref_k - 1)) ||
                           (aref_k == 1 && cyc >= t && cyc <= r0);
            bus.rd_trig  = (cyc == trig_c);
            if (cyc == rst_c) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_cmd",   32'(bus.rd_cmd),     32'(CMD_NOP));
                check("rst_addr",  32'(bus.rd_addr),    32'd0);
                check("rst_bank",  32'(bus.bank_addr),  32'd0);
                check("rst_de",    32'(bus.rd_data_en), 32'd0);
                check("rst_req",   32'(bus.rd_req),     32'd0);
                check("rst_end",   32'(bus.rd_end),     32'd0);
            end
            @(negedge sclk);
        end
        bus.rd_en    = 1'b0;
        bus.aref_req = 1'b0;
        bus.rd_trig  = 1'b0;

        if (rst_off > 0) begin
            rst_n       = 1'b1;
            mdl_col     = 0;
            mdl_row     = 0;
            mdl_bank    = 0;
            mdl_pending = 1'b0;
        end else begin
            if (full) mdl_pending = (trig_c >= last);
            else      mdl_pending = mdl_pending || (trig_c >= 0);
            mdl_col = mdl_col + BL * n;
            if (mdl_col == COL_END) begin
                mdl_col = 0;
                if (mdl_row == ROW_END - 1) begin
                    mdl_row  = 0;
                    mdl_bank = (mdl_bank + 1) % 4;
                end else begin
                    mdl_row = mdl_row + 1;
                end
            end
        end
        check("req_after_grant", 32'(bus.rd_req), 32'(mdl_pending));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_trig  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.aref_req = 1'b0;
        mdl_col      = 0;
        mdl_row      = 0;
        mdl_bank     = 0;
        mdl_pending  = 1'b0;

        repeat (3) @(negedge sclk);
        check("reset_cmd",  32'(bus.rd_cmd),     32'(CMD_NOP));
        check("reset_addr", 32'(bus.rd_addr),    32'd0);
        check("reset_bank", 32'(bus.bank_addr),  32'd0);
        check("reset_req",  32'(bus.rd_req),     32'd0);
        check("reset_end",  32'(bus.rd_end),     32'd0);
        check("reset_de",   32'(bus.rd_data_en), 32'd0);
        rst_n = 1'b1;
        @(negedge sclk);

        trig();
        check("req_after_trig", 32'(bus.rd_req), 32'd1);

        // full row 0 bank 0, 64 READs
        grant(0, 0, 0, 0);
        // refresh stop after 6th READ, stray rd_en while streaming
        trig();
        grant(6, 0, 10, 0);
        // resume at col 24 of row 1, trigger coincides with the row wrap
        grant(0, -1, 0, 0);
        // row walk wrapped: row 0, bank 1
        grant(0, 0, 0, 0);
        // refresh high at grant: one burst; reset hits during DRAIN
        trig();
        grant(1, 0, 0, 7);
        // after reset the walk restarts at row 0 bank 0 col 0
        trig();
        grant(1, 0, 0, 0);

        repeat (4) @(negedge sclk);
        check("ev_queue_empty", 32'(ev_q.size()), 32'd0);
        check("de_queue_empty", 32'(de_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
